// File: rtl/mult_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : mult_unit_if
// Description : Request/result bundle between the EX stage and mult_unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface mult_unit_if #(
  parameter int WIDTH     = 32,
  parameter int OPT_WIDTH = 7
);
  logic                 start;
  logic [OPT_WIDTH-1:0] opt;
  logic [WIDTH-1:0]     opr1;
  logic [WIDTH-1:0]     opr2;
  logic                 flush;
  logic                 busy;
  logic                 done;
  logic [WIDTH-1:0]     hi;
  logic [WIDTH-1:0]     lo;
  logic                 illegal_opt;

  modport master (
    output start, opt, opr1, opr2, flush,
    input  busy, done, hi, lo, illegal_opt
  );

  modport slave (
    input  start, opt, opr1, opr2, flush,
    output busy, done, hi, lo, illegal_opt
  );
endinterface
`default_nettype wire

// File: rtl/mult_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_unit
// Description : Multi-cycle signed multiplier (radix-2 shift-add on operand
//               magnitudes plus a one-cycle sign fix) producing HI/LO.
//               Optional macro MULT_EARLY_TERM_EN ends the shift-add loop as
//               soon as the remaining multiplier bits are all zero.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_unit #(
  parameter int WIDTH     = 32,
  parameter int OPT_WIDTH = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  mult_unit_if.slave  bus
);

  localparam int                   c_CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [OPT_WIDTH-1:0] c_OPT_MULT = OPT_WIDTH'(7'h18);
  localparam logic [c_CNT_W-1:0]   c_CNT_LAST = c_CNT_W'(WIDTH - 1);
  localparam logic [c_CNT_W-1:0]   c_CNT_ONE  = c_CNT_W'(1);

  localparam logic [1:0] c_S_IDLE = 2'd0;
  localparam logic [1:0] c_S_CALC = 2'd1;
  localparam logic [1:0] c_S_SIGN = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mplier;
  logic [c_CNT_W-1:0] r_count;
  logic               r_neg;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_busy;
  logic               r_done;
  logic               r_illegal;

  logic               w_is_mult;
  logic               w_accept;
  logic               w_calc_last;
  logic               w_busy_nxt;
  logic               w_done_nxt;
  logic               w_illegal_nxt;
  logic [WIDTH-1:0]   w_mag1;
  logic [WIDTH-1:0]   w_mag2;
  logic [WIDTH-1:0]   w_mplier_shr;
  logic [2*WIDTH-1:0] w_acc_sum;
  logic [2*WIDTH-1:0] w_signed_prod;

  // Magnitudes stay unsigned, so the most negative operand maps to itself.
  assign w_mag1        = bus.opr1[WIDTH-1] ? (-bus.opr1) : bus.opr1;
  assign w_mag2        = bus.opr2[WIDTH-1] ? (-bus.opr2) : bus.opr2;
  assign w_is_mult     = (bus.opt == c_OPT_MULT);
  assign w_accept      = (r_state == c_S_IDLE) && bus.start && !bus.flush && w_is_mult;
  assign w_mplier_shr  = r_mplier >> 1;
  assign w_acc_sum     = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_signed_prod = r_neg ? (-r_acc) : r_acc;

`ifdef MULT_EARLY_TERM_EN
  assign w_calc_last = (r_count == c_CNT_LAST) || (w_mplier_shr == '0);
`else
  assign w_calc_last = (r_count == c_CNT_LAST);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_S_IDLE: if (w_accept) w_state_nxt = c_S_CALC;
      c_S_CALC: begin
        if (bus.flush)        w_state_nxt = c_S_IDLE;
        else if (w_calc_last) w_state_nxt = c_S_SIGN;
      end
      c_S_SIGN: w_state_nxt = c_S_IDLE;
      default:  w_state_nxt = c_S_IDLE;
    endcase
  end

  // Flush in IDLE drops the request entirely, including the illegal-opt flag.
  always_comb begin
    w_busy_nxt    = (w_state_nxt != c_S_IDLE);
    w_done_nxt    = (r_state == c_S_SIGN) && !bus.flush;
    w_illegal_nxt = (r_state == c_S_IDLE) && bus.start && !bus.flush && !w_is_mult;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand   <= '0;
      r_acc     <= '0;
      r_mplier  <= '0;
      r_count   <= '0;
      r_neg     <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_illegal <= w_illegal_nxt;
      if (w_accept) begin
        r_mcand  <= {{WIDTH{1'b0}}, w_mag1};
        r_mplier <= w_mag2;
        r_neg    <= bus.opr1[WIDTH-1] ^ bus.opr2[WIDTH-1];
        r_acc    <= '0;
        r_count  <= '0;
      end else if (r_state == c_S_CALC) begin
        r_acc    <= w_acc_sum;
        r_mcand  <= r_mcand << 1;
        r_mplier <= w_mplier_shr;
        r_count  <= r_count + c_CNT_ONE;
      end
      if (w_done_nxt) begin
        r_hi <= w_signed_prod[2*WIDTH-1:WIDTH];
        r_lo <= w_signed_prod[WIDTH-1:0];
      end
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;
  assign bus.illegal_opt = r_illegal;

endmodule
`default_nettype wire

// File: doc/mult_unit.md
Name: mult_unit

Overview:
- Multi-cycle signed multiplier for the EX stage; performs the `ALU_OPT_MULT` (7'h18) work that the combinational ALU passes through without computing.
- The EX stage sees opt 7'h18, pulses `start`, stalls on `busy`, and captures the product into HI/LO on `done`.
- Radix-2 iterative shift-add on operand magnitudes, followed by a one-cycle sign fix.

Parameters:
- WIDTH, 32, operand width; `hi`/`lo` are each WIDTH bits.
- OPT_WIDTH, 7, width of `opt`; must match the ALU opt encoding.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request strobe; sampled only in IDLE.
- opt  in  OPT_WIDTH  operation code; 7'h18 = MULT (signed).
- opr1  in  WIDTH  multiplicand (rs).
- opr2  in  WIDTH  multiplier (rt).
- flush  in  1  pipeline flush; aborts the operation in flight.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse; `hi`/`lo` are valid and newly updated.
- hi  out  WIDTH  upper half of the 2*WIDTH-bit product (HI register).
- lo  out  WIDTH  lower half of the product (LO register).
- illegal_opt  out  1  one-cycle pulse when `start` arrives with an unsupported opt.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - busy=0, done=0, illegal_opt=0, hi=0, lo=0.
  - All internal regs cleared.
- Reset mid-operation: abort immediately; HI/LO return to 0.
- States: IDLE, CALC, SIGN.
  - busy = (state != IDLE), registered decode.
- IDLE, start=1, opt=7'h18:
  - Latch mcand=|opr1| (2*WIDTH bits, zero-extended), mplier=|opr2|, neg=opr1[MSB]^opr2[MSB].
  - acc=0, count=0; go to CALC.
- IDLE, start=1, other opt: no operation started; illegal_opt=1 for the next cycle; state stays IDLE.
- Magnitudes are computed as unsigned WIDTH-bit values, so |0x80000000| = 0x80000000 (no overflow).
- CALC, each edge:
  - If mplier[0]=1, acc += mcand.
  - mcand <<= 1; mplier >>= 1; count++.
  - After the count=WIDTH-1 iteration, go to SIGN.
- SIGN, one edge:
  - {hi,lo} = neg ? (~acc + 1) : acc.
  - done=1 for the next cycle; go to IDLE.
- Latency: start sampled at edge 0; done and new hi/lo visible after edge WIDTH+1 (edge 33 for WIDTH=32), i.e. 34 cycles.
- busy is high from after edge 0 through edge WIDTH+1; it falls in the same cycle done rises.
- Back-to-back: start is accepted in the cycle done is high, since state is IDLE then.
- start while busy is ignored: no queuing, no illegal_opt.
- flush:
  - Any state other than IDLE → IDLE on the next edge.
  - hi/lo unchanged; done not asserted.
  - flush has priority over SIGN completion.
  - flush in IDLE has priority over start: the request is dropped.
- hi/lo change only on a SIGN completion or reset; they hold otherwise.

Optional Feature:
- Macro: `MULT_EARLY_TERM_EN`.
- Defined:
  - In CALC, go to SIGN when the post-shift mplier==0, or when count reaches WIDTH-1, whichever comes first.
  - Latency = number of significant bits of |opr2| + 2 cycles; minimum 3 (for |opr2| ≤ 1, including opr2=0).
  - Results are identical to the non-defined case.
- Undefined: fixed WIDTH+2 latency regardless of operands.

Test Plan:
- Signed mixed: opr1=7, opr2=0xFFFFFFFD (-3), start=1 → 34 cycles later done=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy low that cycle.
- Corner magnitudes:
  - opr1=opr2=0x80000000 → hi=0x40000000, lo=0x00000000.
  - opr1=opr2=0xFFFFFFFF → hi=0x00000000, lo=0x00000001.
- Flush mid-op: complete 3×4 (hi=0, lo=12); start 5×5; assert flush at cycle 10 → busy=0 next cycle, done never pulses, hi=0, lo=12 retained.
- Protocol:
  - start with opt=7'h21 → illegal_opt pulses 1 cycle, busy stays 0.
  - start re-pulsed while busy → ignored; single done with the first operands' product.
- Reset mid-op: rst_n=0 at cycle 20 of 0x1234×0x10 → hi=lo=0, busy=0 asynchronously; after release, a new 2×3 gives lo=6 at 34 cycles.
- With `MULT_EARLY_TERM_EN`:
  - opr1=100, opr2=1 → done after 3 cycles, lo=100.
  - opr2=0x00000100 → done after 11 cycles, lo=100<<8.
